hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
Central EX-stage hazard controller for the 5-stage RV32 pipeline. It generates the forward_a/forward_b selects that drive the EX operand forwarding muxes, and detects load-use hazards. It sequences multi-cycle EX operations (mul/div) through a small FSM, and issues branch flushes. It drives the pipeline-register write enables and flushes, and keeps saturating stall and flush counters for performance debug.

Parameters:
REG_ADDR_W, 5, register-file address width.
MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal range 2..16.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
if_id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
if_id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_ex_rs1  in  REG_ADDR_W  rs1 of the instruction in EX
id_ex_rs2  in  REG_ADDR_W  rs2 of the instruction in EX
id_ex_rd  in  REG_ADDR_W  rd of the instruction in EX
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_multicycle  in  1  instruction in EX is a multi-cycle op
ex_mem_rd  in  REG_ADDR_W  rd in EX/MEM
ex_mem_reg_write  in  1  EX/MEM writes the register file
mem_wb_rd  in  REG_ADDR_W  rd in MEM/WB
mem_wb_reg_write  in  1  MEM/WB writes the register file
branch_taken  in  1  branch/jump resolved taken in EX
forward_a  out  2  operand A select: 00 = ID/EX, 01 = MEM/WB, 10 = EX/MEM
forward_b  out  2  operand B select, same encoding
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID load enable
id_ex_write  out  1  ID/EX load enable
if_id_flush  out  1  zero IF/ID on the next edge
id_ex_flush  out  1  load a bubble into ID/EX on the next edge
ex_mem_bubble  out  1  load a bubble into EX/MEM on the next edge
stall_count  out  CNT_W  cycles with pc_write=0
flush_count  out  CNT_W  taken-branch flushes

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: FSM=RUN, cnt=0, stall_count=0, flush_count=0.
- Outputs during reset: combinational outputs evaluate as in RUN with no hazards: pc_write, if_id_write and id_ex_write are 1; flushes and bubble are 0.
- Forwarding (combinational, every state):
  - forward_a=10 if ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==id_ex_rs1.
  - Else forward_a=01 if mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==id_ex_rs1.
  - Else forward_a=00.
  - forward_b uses the same rule on id_ex_rs2.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded. Code 11 is never driven.
- Load-use condition, lu: id_ex_mem_read && id_ex_rd!=0 && (id_ex_rd==if_id_rs1 || id_ex_rd==if_id_rs2).
- FSM state RUN, priority high to low:
  - branch_taken: if_id_flush=1 and id_ex_flush=1; all write enables 1; flush_count+1. Load-use is ignored that cycle.
  - id_ex_multicycle: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1; cnt<=MC_LAT-2; next state MC_BUSY.
  - lu: pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle (a bubble follows, so lu does not re-fire); stays in RUN.
  - Otherwise all write enables are 1 and all flushes/bubble are 0.
- FSM state MC_BUSY:
  - cnt!=0: hold (pc_write, if_id_write and id_ex_write all 0), ex_mem_bubble=1, cnt-1.
  - cnt==0 (release cycle): all write enables 1, ex_mem_bubble=0 so the result is captured into EX/MEM; next state RUN.
  - id_ex_multicycle, lu and branch_taken are not evaluated in MC_BUSY.
- Multi-cycle latency: the op occupies EX for exactly MC_LAT cycles, and the front end stalls MC_LAT-1 cycles.
- Illegal input: branch_taken and id_ex_multicycle asserted together is illegal; cover it with a bench assertion. RTL gives branch priority.
- Counters:
  - stall_count increments on every cycle with pc_write=0.
  - flush_count increments on every branch flush.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: asserting rst in MC_BUSY returns the FSM to RUN with cnt=0 immediately. The counters clear.

Test Plan:
- Forwarding priority: ex_mem_rd=mem_wb_rd=id_ex_rs1=5, both reg_write=1 -> forward_a=10. Clear ex_mem_reg_write -> 01. Set all rd=0 -> 00.
- Load-use: id_ex_mem_read=1, id_ex_rd=7, if_id_rs2=7 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1. Next cycle (bubble in EX) -> no stall.
- Multi-cycle, MC_LAT=4: id_ex_multicycle pulse -> pc_write=0 and ex_mem_bubble=1 for 3 cycles, then a release cycle with ex_mem_bubble=0 -> stall_count=3, then back to RUN.
- Branch vs load-use: branch_taken=1 with lu true -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1; stall_count unchanged.
- Reset mid-op: assert rst in the 2nd MC_BUSY cycle -> state RUN, all counters 0, pc_write=1 before the next clk edge.
- Saturation: CNT_W=3, hold lu stall over 10 hazard cycles -> stall_count stops at 7.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// EX-stage hazard controller: operand forwarding, load-use stall, multi-cycle
// op sequencing, branch flush and saturating stall/flush performance counters.
module hazard_forward_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_multicycle,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  input  logic                  branch_taken,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic {
    RUN,
    MC_BUSY
  } state_t;

  // Cycles spent in MC_BUSY before the release cycle; MC_LAT <= 16 fits in 4 bits.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       lu;
  logic       flush_evt;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  em_wr,
    input logic [REG_ADDR_W-1:0] mw_rd,
    input logic                  mw_wr
  );
    if (em_wr && (em_rd != '0) && (em_rd == rs)) begin
      return 2'b10;
    end else if (mw_wr && (mw_rd != '0) && (mw_rd == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    forward_a = fwd_sel(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
    forward_b = fwd_sel(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
  end

  assign lu = id_ex_mem_read && (id_ex_rd != '0) &&
              ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    flush_evt     = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (id_ex_multicycle) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_nx        = MC_LOAD;
          state_nx      = MC_BUSY;
        end else if (lu) begin
          // ID/EX still loads, but the flush turns the load into a bubble.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MC_BUSY: begin
        if (cnt != '0) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          cnt_nx        = cnt - 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_evt && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: forwarding vector table, directed multi-cycle
// sequences and a randomized run against an occupancy-based reference model.
module tb_hazard_forward_ctrl;

  localparam int unsigned MC_LAT = 4;

  logic       clk;
  logic       rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic       id_ex_mem_read, id_ex_multicycle;
  logic [4:0] ex_mem_rd, mem_wb_rd;
  logic       ex_mem_reg_write, mem_wb_reg_write, branch_taken;

  logic [1:0]  forward_a, forward_b;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble;
  logic [31:0] stall_count, flush_count;

  logic [1:0]  s_forward_a, s_forward_b;
  logic        s_pc_write, s_if_id_write, s_id_ex_write, s_if_id_flush, s_id_ex_flush, s_ex_mem_bubble;
  logic [2:0]  s_stall_count, s_flush_count;

  int errors;
  int checks;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .MC_LAT(MC_LAT), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_multicycle(id_ex_multicycle),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .branch_taken(branch_taken),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_forward_ctrl #(.REG_ADDR_W(5), .MC_LAT(MC_LAT), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_multicycle(id_ex_multicycle),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .branch_taken(branch_taken),
    .forward_a(s_forward_a), .forward_b(s_forward_b),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_bubble(s_ex_mem_bubble),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(branch_taken && id_ex_multicycle))
        else $error("illegal input: branch_taken with id_ex_multicycle");
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
    id_ex_mem_read = 1'b0; id_ex_multicycle = 1'b0;
    ex_mem_rd = '0; ex_mem_reg_write = 1'b0; mem_wb_rd = '0; mem_wb_reg_write = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] em_rd,
                                         input logic em_wr, input logic [4:0] mw_rd,
                                         input logic mw_wr);
    if (em_wr && em_rd != 0 && em_rd == rs) return 2'd2;
    if (mw_wr && mw_rd != 0 && mw_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic longint sat(input longint raw, input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return (raw > top) ? top : raw;
  endfunction

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       mem_read;
    logic [4:0] em_rd;
    logic       em_wr;
    logic [4:0] mw_rd;
    logic       mw_wr;
    logic [1:0] fa, fb;
    logic       pcw, idf;
  } vec_t;

  vec_t vecs[9];

  // Random-phase model state: remaining EX occupancy of a multi-cycle op, raw event counts.
  int     occ;
  longint st_raw, fl_raw;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();

    //          id_rs1 id_rs2 ex_rs1 ex_rs2 ex_rd ld  em_rd em_wr mw_rd mw_wr fa  fb  pcw idf
    vecs[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0};
    vecs[3] = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 5'd3, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0};
    vecs[5] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0};
    vecs[6] = '{5'd1, 5'd7, 5'd1, 5'd2, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
    vecs[7] = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0};
    vecs[8] = '{5'd6, 5'd0, 5'd1, 5'd2, 5'd6, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0};

    // Reset state, sampled while rst is held.
    #3;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_id_ex_write", id_ex_write, 1);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_bubble", ex_mem_bubble, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);

    // Forwarding / load-use vector table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if_id_rs1 = vecs[i].id_rs1; if_id_rs2 = vecs[i].id_rs2;
      id_ex_rs1 = vecs[i].ex_rs1; id_ex_rs2 = vecs[i].ex_rs2; id_ex_rd = vecs[i].ex_rd;
      id_ex_mem_read = vecs[i].mem_read;
      ex_mem_rd = vecs[i].em_rd; ex_mem_reg_write = vecs[i].em_wr;
      mem_wb_rd = vecs[i].mw_rd; mem_wb_reg_write = vecs[i].mw_wr;
      @(negedge clk);
      chk($sformatf("vec%0d_forward_a", i), forward_a, vecs[i].fa);
      chk($sformatf("vec%0d_forward_b", i), forward_b, vecs[i].fb);
      chk($sformatf("vec%0d_pc_write", i), pc_write, vecs[i].pcw);
      chk($sformatf("vec%0d_id_ex_flush", i), id_ex_flush, vecs[i].idf);
      tick();
    end

    // Load-use: one stall cycle, then the bubble in EX removes the hazard.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs2 = 5'd7;
    @(negedge clk);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_id_ex_write", id_ex_write, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    tick();
    id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
    @(negedge clk);
    chk("lu_next_pc_write", pc_write, 1);
    chk("lu_next_id_ex_flush", id_ex_flush, 0);
    chk("lu_stall_count", stall_count, 1);

    // Multi-cycle op: MC_LAT-1 stall cycles then a release cycle.
    do_reset();
    id_ex_multicycle = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mc_stall%0d_pc_write", c), pc_write, 0);
      chk($sformatf("mc_stall%0d_id_ex_write", c), id_ex_write, 0);
      chk($sformatf("mc_stall%0d_bubble", c), ex_mem_bubble, 1);
      tick();
      id_ex_multicycle = 1'b0;
    end
    @(negedge clk);
    chk("mc_release_pc_write", pc_write, 1);
    chk("mc_release_id_ex_write", id_ex_write, 1);
    chk("mc_release_bubble", ex_mem_bubble, 0);
    chk("mc_release_stall_count", stall_count, 3);
    tick();
    @(negedge clk);
    chk("mc_after_pc_write", pc_write, 1);
    chk("mc_after_stall_count", stall_count, 3);

    // Branch outranks a simultaneous load-use.
    do_reset();
    branch_taken = 1'b1;
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7;
    @(negedge clk);
    chk("br_if_id_flush", if_id_flush, 1);
    chk("br_id_ex_flush", id_ex_flush, 1);
    chk("br_pc_write", pc_write, 1);
    chk("br_if_id_write", if_id_write, 1);
    tick();
    clear_inputs();
    @(negedge clk);
    chk("br_flush_count", flush_count, 1);
    chk("br_stall_count", stall_count, 0);

    // Asynchronous reset during the second MC_BUSY cycle.
    do_reset();
    id_ex_multicycle = 1'b1;
    tick();
    id_ex_multicycle = 1'b0;
    tick();
    @(negedge clk);
    chk("rstmid_busy_pc_write", pc_write, 0);
    chk("rstmid_busy_stall_count", stall_count, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_pc_write", pc_write, 1);
    chk("rstmid_bubble", ex_mem_bubble, 0);
    chk("rstmid_stall_count", stall_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_after_pc_write", pc_write, 1);
    chk("rstmid_after_stall_count", stall_count, 0);

    // Saturation: a held load-use hazard for 10 cycles.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("sat_small_stall_count", s_stall_count, 7);
    chk("sat_wide_stall_count", stall_count, 10);

    // Randomized run against the occupancy model.
    do_reset();
    occ = 0; st_raw = 0; fl_raw = 0;
    for (int n = 0; n < 500; n++) begin
      logic [1:0] efa, efb;
      logic epcw, eifw, eidw, eiff, eidf, eb, fev, lu_ref;
      if_id_rs1 = 5'($urandom_range(0, 3)); if_id_rs2 = 5'($urandom_range(0, 3));
      id_ex_rs1 = 5'($urandom_range(0, 3)); id_ex_rs2 = 5'($urandom_range(0, 3));
      id_ex_rd  = 5'($urandom_range(0, 3));
      ex_mem_rd = 5'($urandom_range(0, 3)); mem_wb_rd = 5'($urandom_range(0, 3));
      id_ex_mem_read   = ($urandom_range(0, 9) < 3);
      ex_mem_reg_write = $urandom_range(0, 1) == 1;
      mem_wb_reg_write = $urandom_range(0, 1) == 1;
      branch_taken     = ($urandom_range(0, 9) == 0);
      id_ex_multicycle = !branch_taken && ($urandom_range(0, 11) == 0);

      efa = ref_fwd(id_ex_rs1, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
      efb = ref_fwd(id_ex_rs2, ex_mem_rd, ex_mem_reg_write, mem_wb_rd, mem_wb_reg_write);
      lu_ref = id_ex_mem_read && id_ex_rd != 0 &&
               (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
      epcw = 1; eifw = 1; eidw = 1; eiff = 0; eidf = 0; eb = 0; fev = 0;
      if (occ >= 2) begin
        epcw = 0; eifw = 0; eidw = 0; eb = 1;
      end else if (occ == 1) begin
        epcw = 1;
      end else if (branch_taken) begin
        eiff = 1; eidf = 1; fev = 1;
      end else if (id_ex_multicycle) begin
        epcw = 0; eifw = 0; eidw = 0; eb = 1;
      end else if (lu_ref) begin
        epcw = 0; eifw = 0; eidf = 1;
      end

      @(negedge clk);
      chk("rnd_forward_a", forward_a, efa);
      chk("rnd_forward_b", forward_b, efb);
      chk("rnd_pc_write", pc_write, epcw);
      chk("rnd_if_id_write", if_id_write, eifw);
      chk("rnd_id_ex_write", id_ex_write, eidw);
      chk("rnd_if_id_flush", if_id_flush, eiff);
      chk("rnd_id_ex_flush", id_ex_flush, eidf);
      chk("rnd_ex_mem_bubble", ex_mem_bubble, eb);
      chk("rnd_stall_count", stall_count, sat(st_raw, 32));
      chk("rnd_flush_count", flush_count, sat(fl_raw, 32));
      chk("rnd_small_stall_count", s_stall_count, sat(st_raw, 3));
      chk("rnd_small_flush_count", s_flush_count, sat(fl_raw, 3));

      if (!epcw) st_raw++;
      if (fev) fl_raw++;
      if (occ > 0) occ--;
      else if (id_ex_multicycle && !branch_taken) occ = MC_LAT - 1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
